// File: rtl/result_bcd_display_pkg.sv
// rtl/result_bcd_display_pkg.sv - shared FSM states and 7-segment encoding for result_bcd_display
package result_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 never come out of double-dabble and map to blank.
    function automatic logic [6:0] seg_lut(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_lut = 7'h40;
            4'd1:    seg_lut = 7'h79;
            4'd2:    seg_lut = 7'h24;
            4'd3:    seg_lut = 7'h30;
            4'd4:    seg_lut = 7'h19;
            4'd5:    seg_lut = 7'h12;
            4'd6:    seg_lut = 7'h02;
            4'd7:    seg_lut = 7'h78;
            4'd8:    seg_lut = 7'h00;
            4'd9:    seg_lut = 7'h10;
            default: seg_lut = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/result_bcd_display_if.sv
// rtl/result_bcd_display_if.sv - result capture and display bus between multiplier and BCD stage
interface result_bcd_display_if #(
    parameter int WORD_LENGTH = 9,
    parameter int DIGITS      = 6
);
    logic                       ready_in;
    logic [2*WORD_LENGTH-1:0]   Result;
    logic                       busy;
    logic                       done;
    logic                       neg;
    logic [4*DIGITS-1:0]        Bcd;
    logic [7*DIGITS-1:0]        seg;

    modport master (
        output ready_in, Result,
        input  busy, done, neg, Bcd, seg
    );

    modport slave (
        input  ready_in, Result,
        output busy, done, neg, Bcd, seg
    );
endinterface

// File: rtl/result_bcd_display_bcd_to_7seg.sv
// rtl/result_bcd_display_bcd_to_7seg.sv - one BCD digit to active-low 7-segment pattern with blanking
module result_bcd_display_bcd_to_7seg
    import result_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = blank ? SEG_BLANK : seg_lut(digit);
    end
endmodule

// File: rtl/result_bcd_display.sv
// rtl/result_bcd_display.sv - captures Result on ready rising edge, double-dabble to BCD, drives 7-seg
module result_bcd_display
    import result_bcd_display_pkg::*;
#(
    parameter int WORD_LENGTH = 9,
    parameter int DIGITS      = 6,
    parameter int SIGNED_IN   = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic             clk,
    input  logic             reset,
    result_bcd_display_if.slave bus
);
    localparam int IN_W  = 2 * WORD_LENGTH;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;

    state_e             state_q, state_d;
    logic               ready_q;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               neg_n_q, neg_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               neg_q, neg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [SEG_W-1:0]   seg_q, seg_d;

    logic               trigger;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shift_scratch;
    logic [DIGITS-1:0]  blank;
    logic               zero_above;
    logic [SEG_W-1:0]   dec_seg;

    assign trigger = bus.ready_in & ~ready_q;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                         : scratch_q[4*i +: 4];
        end
        shift_scratch = (adj << 1) | BCD_W'(bin_q[IN_W-1]);
    end

    // Leading-zero blanking on the value about to be published; units digit is never blanked.
    always_comb begin
        blank      = '0;
        zero_above = (BLANK_LZ != 0);
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (shift_scratch[4*i +: 4] == 4'd0);
            blank[i]   = zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        result_bcd_display_bcd_to_7seg u_dec (
            .digit (shift_scratch[4*g +: 4]),
            .blank (blank[g]),
            .seg   (dec_seg[7*g +: 7])
        );
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        neg_n_d   = neg_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    bin_d   = bus.Result;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if ((SIGNED_IN != 0) && bin_q[IN_W-1]) begin
                    bin_d   = -bin_q;
                    neg_n_d = 1'b1;
                end else begin
                    neg_n_d = 1'b0;
                end
                scratch_d = '0;
                count_d   = CNT_W'(IN_W);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                scratch_d = shift_scratch;
                bin_d     = {bin_q[IN_W-2:0], 1'b0};
                count_d   = count_q - CNT_W'(1);
                // Publish on the final shift so outputs and done appear together in DONE.
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = shift_scratch;
                    neg_d   = neg_n_q;
                    seg_d   = dec_seg;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            bin_q     <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            neg_n_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= '1;
        end else begin
            state_q   <= state_d;
            ready_q   <= bus.ready_in;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            neg_n_q   <= neg_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.neg  = neg_q;
    assign bus.Bcd  = bcd_q;
    assign bus.seg  = seg_q;

endmodule
